// File: rtl/sha256_compress_core.sv
// SHA-256 compression engine: one 512-bit padded block per transaction,
// ROUNDS_PER_CYCLE rounds per clock, chaining hash state across blocks.
module sha256_compress_core #(
  parameter int unsigned ROUNDS_PER_CYCLE = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         first_i,
  input  logic [511:0] block_i,
  output logic         ready_o,
  output logic         hash_valid_o,
  output logic [255:0] hash_o
);

  localparam int unsigned R          = ROUNDS_PER_CYCLE;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned NUM_WORDS  = 16;
  localparam int unsigned NUM_VARS   = 8;
  localparam int unsigned NUM_ROUNDS = 64;
  localparam int unsigned CNT_W      = 7;
  localparam int unsigned KIDX_W     = 6;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [WORD_W-1:0] K_ROM [NUM_ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Only unroll factors that divide 64 evenly are supported.
  if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rounds_per_cycle
    $error("sha256_compress_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_t;

  function automatic logic [WORD_W-1:0] bsig0(input logic [WORD_W-1:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [WORD_W-1:0] bsig1(input logic [WORD_W-1:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [WORD_W-1:0] ssig0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [WORD_W-1:0] ssig1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  function automatic logic [WORD_W-1:0] ch(input logic [WORD_W-1:0] e,
                                           input logic [WORD_W-1:0] f,
                                           input logic [WORD_W-1:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [WORD_W-1:0] maj(input logic [WORD_W-1:0] a,
                                            input logic [WORD_W-1:0] b,
                                            input logic [WORD_W-1:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  state_t              state_q;
  state_t              state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                first_q;
  logic [WORD_W-1:0]   w_q    [NUM_WORDS];
  logic [WORD_W-1:0]   wv_q   [NUM_VARS];
  logic [WORD_W-1:0]   w_ext  [NUM_WORDS + R];
  logic [WORD_W-1:0]   w_nxt  [NUM_WORDS];
  logic [WORD_W-1:0]   wv_nxt [NUM_VARS];
  logic [WORD_W-1:0]   t1;
  logic [WORD_W-1:0]   t2;
  logic [KIDX_W-1:0]   k_idx;
  logic [255:0]        base_c;
  logic [255:0]        hash_sum_c;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (cnt_q == CNT_W'(NUM_ROUNDS - R)) begin
          state_d = FINAL;
        end
      end
      FINAL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Message schedule: extend the window by R words, then slide it by R.
  always_comb begin
    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
      w_ext[i] = w_q[i];
    end
    for (int unsigned i = NUM_WORDS; i < NUM_WORDS + R; i++) begin
      w_ext[i] = ssig1(w_ext[i-2]) + w_ext[i-7] + ssig0(w_ext[i-15]) + w_ext[i-16];
    end
    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
      w_nxt[i] = w_ext[i+R];
    end
  end

  // R compression rounds chained combinationally; index 0..7 = a..h.
  always_comb begin
    wv_nxt = wv_q;
    t1     = '0;
    t2     = '0;
    k_idx  = '0;
    for (int unsigned k = 0; k < R; k++) begin
      k_idx = cnt_q[KIDX_W-1:0] + KIDX_W'(k);
      t1 = wv_nxt[7] + bsig1(wv_nxt[4]) + ch(wv_nxt[4], wv_nxt[5], wv_nxt[6])
         + K_ROM[k_idx] + w_ext[k];
      t2 = bsig0(wv_nxt[0]) + maj(wv_nxt[0], wv_nxt[1], wv_nxt[2]);
      wv_nxt[7] = wv_nxt[6];
      wv_nxt[6] = wv_nxt[5];
      wv_nxt[5] = wv_nxt[4];
      wv_nxt[4] = wv_nxt[3] + t1;
      wv_nxt[3] = wv_nxt[2];
      wv_nxt[2] = wv_nxt[1];
      wv_nxt[1] = wv_nxt[0];
      wv_nxt[0] = t1 + t2;
    end
  end

  // Feed-forward sum onto the chaining base chosen when the block was accepted.
  always_comb begin
    base_c     = first_q ? IV : hash_o;
    hash_sum_c = '0;
    for (int unsigned i = 0; i < NUM_VARS; i++) begin
      hash_sum_c[255-32*i -: 32] = base_c[255-32*i -: 32] + wv_q[i];
    end
  end

  // Datapath: block/working-state load on accept, round update while running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      first_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
        w_q[i] <= '0;
      end
      for (int unsigned i = 0; i < NUM_VARS; i++) begin
        wv_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            cnt_q   <= '0;
            first_q <= first_i;
            for (int unsigned i = 0; i < NUM_WORDS; i++) begin
              w_q[i] <= block_i[511-32*i -: 32];
            end
            for (int unsigned i = 0; i < NUM_VARS; i++) begin
              wv_q[i] <= first_i ? IV[255-32*i -: 32] : hash_o[255-32*i -: 32];
            end
          end
        end
        ROUND: begin
          cnt_q <= cnt_q + CNT_W'(R);
          w_q   <= w_nxt;
          wv_q  <= wv_nxt;
        end
        default: begin
        end
      endcase
    end
  end

  // Registered outputs: ready tracks the next state, hash updates only at FINAL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_o      <= 1'b1;
      hash_valid_o <= 1'b0;
      hash_o       <= IV;
    end else begin
      ready_o      <= (state_d == IDLE);
      hash_valid_o <= (state_q == FINAL);
      if (state_q == FINAL) begin
        hash_o <= hash_sum_c;
      end
    end
  end

endmodule

// File: tb/tb_sha256_compress_core.sv
// Directed bench for sha256_compress_core against known SHA-256 digests.
module tb_sha256_compress_core;

  localparam logic [255:0] IV_H    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_H   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_H = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_H   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [511:0] ABC_BLK   = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, {15{32'h0}}};
  // 56-byte message: the 0x80 terminator fits in block 1, block 2 carries only the length.
  localparam logic [511:0] TWO_BLK1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] TWO_BLK2  = {{15{32'h0}}, 32'h000001c0};

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic         first_i;
  logic [511:0] block_i;

  logic         ready_o, hash_valid_o;
  logic [255:0] hash_o;
  logic         ready1, valid1, ready4, valid4, ready8, valid8;
  logic [255:0] hash1, hash4, hash8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sha256_compress_core #(.ROUNDS_PER_CYCLE(2)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .first_i(first_i), .block_i(block_i),
    .ready_o(ready_o), .hash_valid_o(hash_valid_o), .hash_o(hash_o)
  );
  sha256_compress_core #(.ROUNDS_PER_CYCLE(1)) dut_r1 (
    .clk(clk), .rst(rst), .start_i(start_i), .first_i(first_i), .block_i(block_i),
    .ready_o(ready1), .hash_valid_o(valid1), .hash_o(hash1)
  );
  sha256_compress_core #(.ROUNDS_PER_CYCLE(4)) dut_r4 (
    .clk(clk), .rst(rst), .start_i(start_i), .first_i(first_i), .block_i(block_i),
    .ready_o(ready4), .hash_valid_o(valid4), .hash_o(hash4)
  );
  sha256_compress_core #(.ROUNDS_PER_CYCLE(8)) dut_r8 (
    .clk(clk), .rst(rst), .start_i(start_i), .first_i(first_i), .block_i(block_i),
    .ready_o(ready8), .hash_valid_o(valid8), .hash_o(hash8)
  );

  // Present a start for one edge, then scramble the block to prove it was latched.
  task automatic drive_start(input logic f, input logic [511:0] b);
    start_i = 1'b1;
    first_i = f;
    block_i = b;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    first_i = 1'($urandom);
    block_i = {16{$urandom}};
  endtask

  // Edges from the accept edge until the main instance pulses valid; -1 on timeout.
  task automatic wait_valid(output int edges);
    edges = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (hash_valid_o) begin
        edges = n;
        return;
      end
    end
  endtask

  task automatic test_reset;
    int e;
    rst = 1'b0; start_i = 1'b0; first_i = 1'b0; block_i = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    total++; if (hash_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", hash_valid_o); end
    total++; if (hash_o !== IV_H) begin bad++; $display("FAIL reset_hash: got %h want %h", hash_o, IV_H); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    drive_start(1'b1, ABC_BLK);
    wait_valid(e);
    total++; if (e !== 33) begin bad++; $display("FAIL abc_latency: got %0d want 33", e); end
    total++; if (hash_o !== ABC_H) begin bad++; $display("FAIL abc_hash: got %h want %h", hash_o, ABC_H); end
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL abc_ready_in_valid: got %b want 1", ready_o); end
  endtask

  task automatic test_empty_sweep;
    int       lat [4];
    int       want_lat [4];
    logic [255:0] hv [4];
    logic [3:0]   v;
    want_lat = '{65, 33, 17, 9};
    for (int i = 0; i < 4; i++) begin lat[i] = -1; hv[i] = '0; end
    for (int n = 0; n < 200 && !(ready_o && ready1 && ready4 && ready8); n++) begin
      @(posedge clk);
      #1;
    end
    drive_start(1'b1, EMPTY_BLK);
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      v = {valid8, valid4, hash_valid_o, valid1};
      if (v[0] && lat[0] < 0) begin lat[0] = n; hv[0] = hash1;  end
      if (v[1] && lat[1] < 0) begin lat[1] = n; hv[1] = hash_o; end
      if (v[2] && lat[2] < 0) begin lat[2] = n; hv[2] = hash4;  end
      if (v[3] && lat[3] < 0) begin lat[3] = n; hv[3] = hash8;  end
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (lat[i] !== want_lat[i]) begin
        bad++; $display("FAIL empty_latency_%0d: got %0d want %0d", i, lat[i], want_lat[i]);
      end
      total++;
      if (hv[i] !== EMPTY_H) begin
        bad++; $display("FAIL empty_hash_%0d: got %h want %h", i, hv[i], EMPTY_H);
      end
    end
  endtask

  task automatic test_back_to_back;
    int e;
    drive_start(1'b1, TWO_BLK1);
    wait_valid(e);
    total++; if (e !== 33) begin bad++; $display("FAIL b2b_blk1_latency: got %0d want 33", e); end
    // Issue block 2 inside the valid cycle: no idle gap.
    drive_start(1'b0, TWO_BLK2);
    wait_valid(e);
    total++; if (e !== 33) begin bad++; $display("FAIL b2b_blk2_latency: got %0d want 33", e); end
    total++; if (hash_o !== TWO_H) begin bad++; $display("FAIL b2b_hash: got %h want %h", hash_o, TWO_H); end
  endtask

  task automatic test_chain_reset;
    int e;
    drive_start(1'b1, ABC_BLK);
    wait_valid(e);
    total++; if (e !== 33) begin bad++; $display("FAIL chain_latency: got %0d want 33", e); end
    total++; if (hash_o !== ABC_H) begin bad++; $display("FAIL chain_hash: got %h want %h", hash_o, ABC_H); end
  endtask

  task automatic test_hold_start;
    int           pulses = 0;
    int           e = -1;
    logic [255:0] h = '0;
    drive_start(1'b1, EMPTY_BLK);
    start_i = 1'b1;
    first_i = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (hash_valid_o) begin
        pulses++; e = n; h = hash_o;
        start_i = 1'b0;
        break;
      end
      block_i = {16{$urandom}};
    end
    start_i = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (hash_valid_o) pulses++;
    end
    total++; if (e !== 33) begin bad++; $display("FAIL hold_latency: got %0d want 33", e); end
    total++; if (h !== EMPTY_H) begin bad++; $display("FAIL hold_hash: got %h want %h", h, EMPTY_H); end
    total++; if (pulses !== 1) begin bad++; $display("FAIL hold_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_reset_mid;
    int   e;
    logic saw_valid = 1'b0;
    drive_start(1'b1, ABC_BLK);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b want 1", ready_o); end
    total++; if (hash_o !== IV_H) begin bad++; $display("FAIL midrst_hash: got %h want %h", hash_o, IV_H); end
    repeat (3) begin
      @(posedge clk);
      #1;
      if (hash_valid_o) saw_valid = 1'b1;
    end
    total++; if (saw_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", saw_valid); end
    // Start presented on the very first edge after release.
    @(negedge clk);
    rst = 1'b1;
    start_i = 1'b1; first_i = 1'b1; block_i = ABC_BLK;
    @(posedge clk);
    #1;
    start_i = 1'b0; block_i = {16{$urandom}};
    wait_valid(e);
    total++; if (e !== 33) begin bad++; $display("FAIL midrst_restart_latency: got %0d want 33", e); end
    total++; if (hash_o !== ABC_H) begin bad++; $display("FAIL midrst_restart_hash: got %h want %h", hash_o, ABC_H); end
  endtask

  initial begin
    test_reset();
    test_empty_sweep();
    test_back_to_back();
    test_chain_reset();
    test_hold_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
